// File: rtl/npc_mem_pkg.sv
// rtl/npc_mem_pkg.sv - shared state and owner types for the memory arbiter
package npc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - IFU/LSU grant selection; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties
import npc_mem_pkg::*;

module mem_arb_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic en_i,
    input  logic ifu_valid_i,
    input  logic lsu_valid_i,
    output logic ifu_grant_o,
    output logic lsu_grant_o
);

    logic prefer_lsu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;

    // Resetting to IFU makes LSU the winner of the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWN_IFU;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (lsu_grant_o) begin
            last_d = OWN_LSU;
        end else if (ifu_grant_o) begin
            last_d = OWN_IFU;
        end
    end

    assign prefer_lsu = (last_q == OWN_IFU);
`else
    assign prefer_lsu = 1'b1;
`endif

    always_comb begin
        lsu_grant_o = en_i && lsu_valid_i && (prefer_lsu || !ifu_valid_i);
        ifu_grant_o = en_i && ifu_valid_i && (!prefer_lsu || !lsu_valid_i);
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding IFU/LSU arbiter onto one memory port
// MEM_ARB_ROUND_ROBIN_EN switches tie resolution from fixed LSU priority to round-robin.
import npc_mem_pkg::*;

module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    arb_state_e              state_q, state_d;
    owner_e                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wmask_q, wmask_d;
    logic                    ifu_grant, lsu_grant;

    mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk         (clk),
        .rst         (rst),
`endif
        .en_i        ((state_q == IDLE) && !rst),
        .ifu_valid_i (ifu_req_valid),
        .lsu_valid_i (lsu_req_valid),
        .ifu_grant_o (ifu_grant),
        .lsu_grant_o (lsu_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                ifu_req_ready = ifu_grant;
                lsu_req_ready = lsu_grant;
                if (lsu_grant) begin
                    state_d = REQ;
                    owner_d = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                end else if (ifu_grant) begin
                    // Fetches are always reads: no write enable or byte lanes.
                    state_d = REQ;
                    owner_d = OWN_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                ifu_rsp_valid = mem_rsp_valid && (owner_q == OWN_IFU);
                lsu_rsp_valid = mem_rsp_valid && (owner_q == OWN_LSU);
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_rdata     = mem_rdata;
    assign lsu_rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (honours MEM_ARB_ROUND_ROBIN_EN)
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    typedef struct {
        bit ifu_v; bit lsu_v; bit lsu_wen; int ready_wait;
        bit exp_ifu_rdy; bit exp_lsu_rdy;
    } vec_t;

    vec_t vecs[6];

    // Reference model: one outstanding transaction record plus "issued" flag.
    bit        m_busy, m_issued, m_own_lsu, m_last_lsu;
    bit [31:0] m_addr, m_wdata;
    bit        m_wen;
    bit [3:0]  m_wmask;

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Reset state, with requesters already valid.
        ifu_req_valid = 1; lsu_req_valid = 1; mem_rsp_valid = 1;
        #2;
        chk("rst_ifu_ready", ifu_req_ready, 0);
        chk("rst_lsu_ready", lsu_req_ready, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_ifu_rsp", ifu_rsp_valid, 0);
        chk("rst_lsu_rsp", lsu_rsp_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        tick();
        do_reset();

        // Table of single transactions, each from a fresh reset.
        vecs[0] = '{1, 0, 0, 0, 1, 0};
        vecs[1] = '{0, 1, 0, 1, 0, 1};
        vecs[2] = '{0, 1, 1, 2, 0, 1};
        vecs[3] = '{1, 1, 1, 0, 0, 1};
        vecs[4] = '{1, 1, 0, 3, 0, 1};
        vecs[5] = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            ifu_req_valid = vecs[i].ifu_v; ifu_addr = 32'h1000 + i * 4;
            lsu_req_valid = vecs[i].lsu_v; lsu_addr = 32'h2000 + i * 4;
            lsu_wen = vecs[i].lsu_wen; lsu_wdata = $urandom; lsu_wmask = 4'hf;
            #1;
            chk($sformatf("v%0d_ifu_ready", i), ifu_req_ready, vecs[i].exp_ifu_rdy);
            chk($sformatf("v%0d_lsu_ready", i), lsu_req_ready, vecs[i].exp_lsu_rdy);
            tick();
            ifu_req_valid = 0; lsu_req_valid = 0;
            if (!(vecs[i].exp_ifu_rdy || vecs[i].exp_lsu_rdy)) begin
                chk($sformatf("v%0d_no_req", i), mem_req_valid, 0);
                continue;
            end
            for (int w = 0; w < vecs[i].ready_wait; w++) begin
                chk($sformatf("v%0d_wait_valid", i), mem_req_valid, 1);
                tick();
            end
            mem_req_ready = 1; #1;
            chk($sformatf("v%0d_mem_valid", i), mem_req_valid, 1);
            chk($sformatf("v%0d_mem_addr", i), mem_addr,
                vecs[i].exp_lsu_rdy ? 32'h2000 + i * 4 : 32'h1000 + i * 4);
            chk($sformatf("v%0d_mem_wen", i), mem_wen, vecs[i].exp_lsu_rdy & vecs[i].lsu_wen);
            tick();
            mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hA000 + i; #1;
            chk($sformatf("v%0d_ifu_rsp", i), ifu_rsp_valid, vecs[i].exp_ifu_rdy);
            chk($sformatf("v%0d_lsu_rsp", i), lsu_rsp_valid, vecs[i].exp_lsu_rdy);
            tick();
            mem_rsp_valid = 0;
        end

        // IFU-only fetch with response two cycles after acceptance.
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; #1;
        chk("fetch_ready", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0; mem_req_ready = 1; #1;
        chk("fetch_mem_valid", mem_req_valid, 1);
        chk("fetch_mem_addr", mem_addr, 32'h8000_0000);
        chk("fetch_mem_wen", mem_wen, 0);
        chk("fetch_mem_wmask", mem_wmask, 0);
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0413; #1;
        chk("fetch_rsp_valid", ifu_rsp_valid, 1);
        chk("fetch_rdata", ifu_rdata, 32'h0000_0413);
        chk("fetch_lsu_rsp", lsu_rsp_valid, 0);
        tick();
        mem_rsp_valid = 0; #1;
        chk("fetch_rsp_one_cycle", ifu_rsp_valid, 0);

        // Simultaneous requests: LSU first, IFU right after LSU's response.
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h100; lsu_req_valid = 1; lsu_addr = 32'h200; #1;
        chk("tie_lsu_ready", lsu_req_ready, 1);
        chk("tie_ifu_ready", ifu_req_ready, 0);
        tick();
        mem_req_ready = 1; #1;
        chk("tie_req_ifu_ready", ifu_req_ready, 0);
        chk("tie_mem_addr", mem_addr, 32'h200);
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; lsu_req_valid = 0; #1;
        chk("tie_lsu_rsp", lsu_rsp_valid, 1);
        chk("tie_ifu_not_rsp", ifu_rsp_valid, 0);
        tick();
        mem_rsp_valid = 0; #1;
        chk("tie_ifu_next", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0; #1;
        chk("tie_ifu_mem_addr", mem_addr, 32'h100);

        // Store held under backpressure: fields stable for all four cycles.
        do_reset();
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; #1;
        chk("store_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0;
        for (int c = 0; c < 4; c++) begin
            lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'($urandom); lsu_wen = 0;
            mem_req_ready = (c == 3); #1;
            chk("store_valid", mem_req_valid, 1);
            chk("store_addr", mem_addr, 32'h8000_1000);
            chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("store_wmask", mem_wmask, 4'b0011);
            chk("store_wen", mem_wen, 1);
            tick();
        end
        mem_req_ready = 0; mem_rsp_valid = 1; #1;
        chk("store_done", lsu_rsp_valid, 1);
        tick();
        mem_rsp_valid = 0;

        // Reset while waiting for a response; stale response must be dropped.
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h40; tick();
        ifu_req_valid = 0; mem_req_ready = 1; tick();
        mem_req_ready = 0;
        rst = 1; #1;
        chk("rstmid_mem_valid", mem_req_valid, 0);
        tick();
        rst = 0; mem_rsp_valid = 1; mem_rdata = 32'h1234_5678; #1;
        chk("rstmid_ifu_rsp", ifu_rsp_valid, 0);
        chk("rstmid_lsu_rsp", lsu_rsp_valid, 0);
        tick();
        mem_rsp_valid = 0; lsu_req_valid = 1; lsu_addr = 32'h80; #1;
        chk("rstmid_next_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0; #1;
        chk("rstmid_next_valid", mem_req_valid, 1);
        chk("rstmid_next_addr", mem_addr, 32'h80);

        // Response pulse while idle.
        do_reset();
        mem_rsp_valid = 1; mem_rdata = 32'hFFFF_0000; #1;
        chk("idle_rsp_ifu", ifu_rsp_valid, 0);
        chk("idle_rsp_lsu", lsu_rsp_valid, 0);
        tick();
        mem_rsp_valid = 0; #1;
        chk("idle_rsp_no_req", mem_req_valid, 0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Both requesters held valid: alternate starting with LSU.
        do_reset();
        ifu_req_valid = 1; lsu_req_valid = 1;
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("rr_lsu_grant", lsu_req_ready, (t % 2) == 0);
            chk("rr_ifu_grant", ifu_req_ready, (t % 2) == 1);
            tick();
            mem_req_ready = 1; tick();
            mem_req_ready = 0; mem_rsp_valid = 1; tick();
            mem_rsp_valid = 0;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
`endif

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_busy = 0; m_issued = 0; m_own_lsu = 0; m_last_lsu = 0;
        for (int n = 0; n < 600; n++) begin
            bit pref_lsu, e_ifu, e_lsu;
            ifu_req_valid = ($urandom_range(0, 2) != 0);
            lsu_req_valid = ($urandom_range(0, 2) != 0);
            ifu_addr = $urandom; lsu_addr = $urandom; lsu_wen = 1'($urandom);
            lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
            mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom); mem_rdata = $urandom;
            #1;
            pref_lsu = RR ? !m_last_lsu : 1'b1;
            e_lsu = !m_busy && lsu_req_valid && (pref_lsu || !ifu_req_valid);
            e_ifu = !m_busy && ifu_req_valid && !e_lsu;
            chk("rnd_ifu_ready", ifu_req_ready, e_ifu);
            chk("rnd_lsu_ready", lsu_req_ready, e_lsu);
            chk("rnd_mem_valid", mem_req_valid, m_busy && !m_issued);
            chk("rnd_ifu_rsp", ifu_rsp_valid, m_busy && m_issued && !m_own_lsu && mem_rsp_valid);
            chk("rnd_lsu_rsp", lsu_rsp_valid, m_busy && m_issued && m_own_lsu && mem_rsp_valid);
            if (m_busy && !m_issued) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_wen", mem_wen, m_wen);
                chk("rnd_mem_wmask", mem_wmask, m_wmask);
                if (m_own_lsu) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            if (m_busy && m_issued && mem_rsp_valid)
                chk("rnd_rdata", m_own_lsu ? lsu_rdata : ifu_rdata, mem_rdata);
            if (e_ifu || e_lsu) begin
                m_busy = 1; m_issued = 0; m_own_lsu = e_lsu; m_last_lsu = e_lsu;
                m_addr  = e_lsu ? lsu_addr : ifu_addr;
                m_wen   = e_lsu ? lsu_wen : 1'b0;
                m_wmask = e_lsu ? lsu_wmask : 4'h0;
                m_wdata = lsu_wdata;
            end else if (m_busy && !m_issued && mem_req_ready) begin
                m_issued = 1;
            end else if (m_busy && m_issued && mem_rsp_valid) begin
                m_busy = 0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
